fpgaminer_avmm_csr: RTL
=======================

// Module: fpgaminer_avmm_csr
// PURPOSE
// Avalon-MM slave (s0) of the fpgaminer component: responder end of the host's word writes.
// Holds the 8-word midstate and 3-word block tail and launches jobs to the hashing core
// with a valid/ready handshake. Buffers golden nonces from the core in a small FIFO for host readback.
// PARAMETERS
// NONCE_FIFO_DEPTH  4            golden-nonce FIFO entries (power of 2, 2..16)
// CORE_ID           32'h4650_4D31 constant returned at word 15
// PORTS
// clk                   in   1    single clock for all logic
// reset_n               in   1    asynchronous, active-low reset
// avs_s0_address        in   4    word address (host byte address >> 2)
// avs_s0_write          in   1    write strobe
// avs_s0_writedata      in   32   write data
// avs_s0_byteenable     in   4    per-byte write enable
// avs_s0_read           in   1    read strobe
// avs_s0_readdata       out  32   read data, valid with readdatavalid
// avs_s0_readdatavalid  out  1    one-cycle read-return pulse
// avs_s0_waitrequest    out  1    stall current command
// job_valid             out  1    job offered to core
// job_ready             in   1    core accepts job
// job_midstate          out  256  word0 in [31:0] .. word7 in [255:224]
// job_data              out  96   word8 in [31:0] .. word10 in [95:64]
// core_busy             in   1    core hashing
// core_nonce            in   32   current nonce counter
// golden_valid          in   1    one-cycle golden-nonce pulse
// golden_nonce          in   32   golden nonce value
// BEHAVIOUR
// - Reset: all regs, FIFO, overflow, job_valid, readdatavalid, waitrequest = 0; readdata = 0.
// - Map: 0-7 midstate RW; 8-10 data RW; 11 CTRL WO (reads 0); 12 STATUS RO; 13 NONCE_POP RO;
//   14 CUR_NONCE RO (core_nonce); 15 ID RO (CORE_ID). Writes to RO words ignored, accepted.
// - Writes: byte-granular via byteenable; take effect on the accepting edge (write & ~waitrequest).
// - CTRL bits (write 1, self-clearing): [0] START, [1] FIFO_CLR, [2] OVF_CLR.
// - START sets job_valid next cycle; job_midstate/job_data are the live regs, so they stay
//   stable while job_valid=1 because writes to 0-10, or CTRL with [0]=1, assert waitrequest
//   combinationally until job_valid drops. Job completes on clk edge with job_valid & job_ready;
//   job_valid clears that edge. START while job_valid=1 stalls, never lost or merged.
// - Reads never stall; readdata registered, readdatavalid one cycle after read (latency 1).
//   Read and write strobes asserted together: read address honoured, write ignored and not stalled.
// - STATUS: [0] job_valid|core_busy, [1] FIFO non-empty, [2] FIFO full, [3] overflow sticky,
//   [8:4] FIFO count, rest 0.
// - NONCE_POP read returns head and pops; empty returns 32'h0, no state change.
// - FIFO push on golden_valid. Full push: dropped, overflow=1 (kept until OVF_CLR).
//   Push+pop same cycle: non-empty -> count unchanged, order kept; empty -> pop returns 0,
//   push lands. Full + pop + push: pop frees slot, push accepted, no overflow.
// - FIFO_CLR empties FIFO same edge; golden_valid that cycle is stored (push wins after clear).
// - Pointers wrap modulo NONCE_FIFO_DEPTH; count is separate, 0..DEPTH.
// - Reset mid-job: job_valid drops immediately; core sees no handshake completion.
// TESTING
// - Write i to word i, i=0..7, then read 0..7 -> readdata=i, each readdatavalid 1 cycle after read.
// - Write word 1 byteenable=4'b0010 data 32'hAABBCCDD over 32'h1 -> read 32'h0000CC01.
// - Words 0-10 set, START, job_ready low 10 cycles -> job_valid=1, write to word3 waitrequest=1
//   10 cycles, job_midstate unchanged; job_ready=1 -> job_valid=0, then word3 write completes.
// - 5 golden pulses 1..5, DEPTH=4 -> STATUS count=4, full=1, ovf=1; pops return 1,2,3,4 then 0;
//   OVF_CLR -> STATUS=0 (core idle).
// - golden_valid same cycle as NONCE_POP on 1-entry FIFO -> returns old head, count stays 1.
// - Drop reset_n while job_valid=1 and FIFO holds 2 -> job_valid=0, STATUS=0, word 0 reads 0.

Source files
------------

// File: rtl/fpgaminer_avmm_csr.sv
// fpgaminer_avmm_csr: Avalon-MM register slave for the fpgaminer core.
// Holds the job words (8-word midstate and 3-word block tail), offers them to
// the hashing core with a valid/ready handshake, and queues golden nonces from
// the core in a small FIFO that the host drains by reading.
module fpgaminer_avmm_csr #(
    parameter int          NONCE_FIFO_DEPTH = 4,
    parameter logic [31:0] CORE_ID          = 32'h4650_4D31
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [3:0]   avs_s0_address,
    input  logic         avs_s0_write,
    input  logic [31:0]  avs_s0_writedata,
    input  logic [3:0]   avs_s0_byteenable,
    input  logic         avs_s0_read,
    output logic [31:0]  avs_s0_readdata,
    output logic         avs_s0_readdatavalid,
    output logic         avs_s0_waitrequest,
    output logic         job_valid,
    input  logic         job_ready,
    output logic [255:0] job_midstate,
    output logic [95:0]  job_data,
    input  logic         core_busy,
    input  logic [31:0]  core_nonce,
    input  logic         golden_valid,
    input  logic [31:0]  golden_nonce
);

    localparam int PTR_W = (NONCE_FIFO_DEPTH > 1) ? $clog2(NONCE_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(NONCE_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(NONCE_FIFO_DEPTH);

    typedef enum logic [3:0] {
        ADDR_CTRL   = 4'd11,
        ADDR_STATUS = 4'd12,
        ADDR_POP    = 4'd13,
        ADDR_CUR    = 4'd14,
        ADDR_ID     = 4'd15
    } addr_e;

    logic [31:0]      regs [0:10];
    logic [31:0]      mem  [0:NONCE_FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, mem_waddr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic is_job_word, is_ctrl, start_req;
    logic wr_accept, start, fifo_clr, ovf_clr;
    logic fifo_full, pop, push, mem_we;
    logic [31:0] status, rd_mux;

    // Command decode. A simultaneous read wins: the write is dropped, never stalled.
    // Writes that would disturb an offered job (job words, or a new START) wait
    // until the core has taken the job.
    always_comb begin
        is_job_word        = (avs_s0_address <= 4'd10);
        is_ctrl            = (avs_s0_address == ADDR_CTRL);
        start_req          = is_ctrl & avs_s0_byteenable[0] & avs_s0_writedata[0];
        avs_s0_waitrequest = avs_s0_write & ~avs_s0_read & job_valid & (is_job_word | start_req);
        wr_accept          = avs_s0_write & ~avs_s0_read & ~avs_s0_waitrequest;
        start              = wr_accept & start_req;
        fifo_clr           = wr_accept & is_ctrl & avs_s0_byteenable[0] & avs_s0_writedata[1];
        ovf_clr            = wr_accept & is_ctrl & avs_s0_byteenable[0] & avs_s0_writedata[2];
    end

    // Job word registers with per-byte write enables.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 11; i++) regs[i] <= '0;
        end else if (wr_accept && is_job_word) begin
            // NOTE: state is updated with non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            for (int b = 0; b < 4; b++)
                if (avs_s0_byteenable[b])
                    regs[avs_s0_address][8*b +: 8] <= avs_s0_writedata[8*b +: 8];
        end
    end

    // The job is presented straight from the live registers.
    always_comb begin
        for (int i = 0; i < 8; i++) job_midstate[32*i +: 32] = regs[i];
        for (int i = 0; i < 3; i++) job_data[32*i +: 32]     = regs[8 + i];
    end

    // Job handshake: START raises job_valid, the core's acceptance drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    job_valid <= 1'b0;
        else if (start)                  job_valid <= 1'b1;
        else if (job_valid && job_ready) job_valid <= 1'b0;
    end

    // FIFO control: a pop frees a slot for a same-cycle push, even when full.
    always_comb begin
        fifo_full = (count == DEPTH_C);
        pop       = avs_s0_read & (avs_s0_address == ADDR_POP) & (count != '0);
        push      = golden_valid & (~fifo_full | pop);
        mem_we    = golden_valid & (fifo_clr | ~fifo_full | pop);
        mem_waddr = fifo_clr ? '0 : wr_ptr;
    end

    // FIFO pointers, occupancy and sticky overflow. A clear empties the FIFO
    // but a golden nonce arriving that same cycle is still kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_clr) begin
                rd_ptr <= '0;
                wr_ptr <= golden_valid ? PTR_W'(1) : '0;
                count  <= golden_valid ? CNT_W'(1) : '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            if (golden_valid && fifo_full && !pop && !fifo_clr) overflow <= 1'b1;
            else if (ovf_clr)                                   overflow <= 1'b0;
        end
    end

    // FIFO storage.
    // NOTE: the storage array has no reset; count gates every read, so stale
    // contents are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= golden_nonce;
    end

    // Read-data selection and status word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        status      = '0;
        status[0]   = job_valid | core_busy;
        status[1]   = (count != '0);
        status[2]   = fifo_full;
        status[3]   = overflow;
        status[8:4] = 5'(count);
        rd_mux      = '0;
        case (avs_s0_address)
            ADDR_CTRL:   rd_mux = '0;
            ADDR_STATUS: rd_mux = status;
            ADDR_POP:    rd_mux = (count != '0) ? mem[rd_ptr] : '0;
            ADDR_CUR:    rd_mux = core_nonce;
            ADDR_ID:     rd_mux = CORE_ID;
            default:     rd_mux = regs[avs_s0_address];
        endcase
    end

    // Registered read return, one cycle after the read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_s0_readdata      <= '0;
            avs_s0_readdatavalid <= 1'b0;
        end else begin
            avs_s0_readdatavalid <= avs_s0_read;
            if (avs_s0_read) avs_s0_readdata <= rd_mux;
        end
    end

endmodule
